pipeline_scoreboard: RTL and testbench
======================================

Name: pipeline_scoreboard

Overview:
- Parametrised hazard and interlock controller for the next-generation pipelined core.
- Tracks in-flight destination registers in a DEPTH-entry slot shift chain behind decode.
- From that state it produces per-operand bypass selects, load-use stalls, a multicycle multiply/divide structural interlock, and flush gating of decode issue.
- Sits beside the FD/DX latches; the datapath consumes issue_fire, stall and the fwd selects.

Parameters:
REG_BITS, 5, register-index width; index 0 is the hardwired zero register.
DEPTH, 3, number of tracked stages after decode (slot 1 = X, 2 = M, 3 = W).
LOAD_READY, 2, first slot index at which load data is forwardable; legal range 1..DEPTH.
MD_CYCLES, 32, multiply/divide occupancy in cycles; must be >= 1.

Ports:
clock  in  1  master clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
issue_valid  in  1  decode holds a valid instruction
issue_we  in  1  decode instruction writes a register
issue_rd  in  REG_BITS  decode destination register
issue_is_load  in  1  decode instruction is a load
issue_is_md  in  1  decode instruction is a multicycle mul/div
src_a, src_b  in  REG_BITS  decode source registers ($rs, $rt)
use_a, use_b  in  1  corresponding source is actually read
flush  in  1  branch/jump resolved taken; kill the decode instruction
issue_fire  out  1  decode instruction advances into slot 1 this cycle
stall  out  1  hold PC and FD latch; insert bubble
fwd_a, fwd_b  out  FW=$clog2(DEPTH+1)  0 = regfile, k = bypass from slot k
md_busy  out  1  multicycle unit occupied
slot_valid  out  DEPTH  bit k-1 = slot k holds a register-writing instruction

Behaviour:
- Slot k state: valid, rd, is_load. Only instructions with issue_we=1 and issue_rd!=0 create valid entries; all other fired instructions enter as bubbles.
- Every clock: slot[k+1] <= slot[k] unconditionally; slot[DEPTH] drops off.
- Slot 1 loads in this priority order:
  - the md entry on the md completion edge;
  - else the decode entry if issue_fire;
  - else a bubble.
- Match(src, k): use=1 & slot[k].valid & slot[k].rd==src & src!=0.
- fwd_x: smallest k with Match (youngest wins), else 0. Combinational from current state and inputs.
- Load-use: stall_ld = the youngest match on either operand is a load in slot k < LOAD_READY.
- MD counter: md_cnt of width clog2(MD_CYCLES+1); md_busy = (md_cnt != 0).
  - When an md instruction fires: slot 1 <= bubble, md_cnt <= MD_CYCLES, and md_rd/md_we are captured.
  - While md_cnt > 1: md_cnt decrements each clock.
  - When md_cnt == 1: next edge md_cnt <= 0 and slot 1 <= md entry.
- stall = issue_valid & (stall_ld | md_busy). Any instruction, dependent or not, waits while md_busy.
- issue_fire = issue_valid & ~stall & ~flush. flush has priority; stall is still reported but issue is blocked.
- flush does not touch slots or md_cnt; the in-flight md is older than the branch and completes.
- An md fire with flush asserted is discarded.
- Reset (reset==0, asynchronous): all slots invalid, md_cnt=0, md capture regs=0.
  - Resulting outputs: slot_valid=0, md_busy=0, fwd_a=fwd_b=0, stall=0, issue_fire=issue_valid & ~flush.
  - Reset mid-md aborts the operation with no slot injection.
- Release of reset is synchronised by the clock domain owner; the block takes no action on deassertion beyond resuming on the next edge.

Test Plan:
- Reset: fill all 3 slots and start md, pull reset=0 between edges -> slot_valid=3'b000, md_busy=0, stall=0 immediately, no md injection after release.
- ALU chain: fire add r3 at t; consumer src_a=3, use_a=1 -> fwd_a=1 at t+1, 2 at t+2, 3 at t+3, 0 at t+4, stall never asserted.
- Load-use: fire load r5 at t; consumer src_b=5 at t+1 -> stall=1, issue_fire=0 at t+1; at t+2 stall=0, fwd_b=2, issue_fire=1.
- Zero register and youngest-wins:
  - writer to r0 then reader of r0 -> fwd_a=0, slot_valid[0]=0.
  - two writers to r4 in slots 1 and 2 -> fwd_a=1.
- MD (MD_CYCLES=4): mul r7 fires at t -> md_busy=1 for t+1..t+4, unrelated issue_valid stalls throughout. At t+5 slot_valid[0]=1 and a consumer of r7 fires with fwd_a=1.
- Flush:
  - issue_valid=1, flush=1, no hazard -> issue_fire=0, slot_valid[0]=0 next cycle.
  - flush during md_busy -> md still injects r7 on schedule.

Source files
------------

// File: rtl/pipeline_scoreboard_if.sv
// Decode-side hazard interface: issue request and operand info in, interlock/bypass controls out.
interface pipeline_scoreboard_if #(
    parameter int REG_BITS = 5,
    parameter int DEPTH    = 3
);
    localparam int FW = $clog2(DEPTH + 1);

    logic                issue_valid;
    logic                issue_we;
    logic [REG_BITS-1:0] issue_rd;
    logic                issue_is_load;
    logic                issue_is_md;
    logic [REG_BITS-1:0] src_a;
    logic [REG_BITS-1:0] src_b;
    logic                use_a;
    logic                use_b;
    logic                flush;
    logic                issue_fire;
    logic                stall;
    logic [FW-1:0]       fwd_a;
    logic [FW-1:0]       fwd_b;
    logic                md_busy;
    logic [DEPTH-1:0]    slot_valid;

    modport slave (
        input  issue_valid, issue_we, issue_rd, issue_is_load, issue_is_md,
               src_a, src_b, use_a, use_b, flush,
        output issue_fire, stall, fwd_a, fwd_b, md_busy, slot_valid
    );

    modport master (
        output issue_valid, issue_we, issue_rd, issue_is_load, issue_is_md,
               src_a, src_b, use_a, use_b, flush,
        input  issue_fire, stall, fwd_a, fwd_b, md_busy, slot_valid
    );
endinterface

// File: rtl/pipeline_scoreboard.sv
// Hazard/interlock controller: tracks in-flight destinations, drives bypass selects, load-use and mul/div stalls.
// Outputs are combinational from slot state and decode inputs; slots advance every clock.
module pipeline_scoreboard #(
    parameter int REG_BITS   = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int MD_CYCLES  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    pipeline_scoreboard_if.slave  sb
);
    localparam int FW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(MD_CYCLES + 1);

    logic [DEPTH-1:0]    slot_vld_q;
    logic [DEPTH-1:0]    slot_ld_q;
    logic [REG_BITS-1:0] slot_rd_q [DEPTH];

    logic [CW-1:0]       md_cnt_q, md_cnt_d;
    logic [REG_BITS-1:0] md_rd_q, md_rd_d;
    logic                md_we_q, md_we_d;

    logic                slot1_vld_d, slot1_ld_d;
    logic [REG_BITS-1:0] slot1_rd_d;

    logic [FW-1:0]       fwd_a, fwd_b;
    logic                ld_hit_a, ld_hit_b;
    logic                md_busy, md_done, md_fire;
    logic                stall, fire;

    // Scan oldest to youngest so the youngest matching slot is the last one written.
    always_comb begin
        fwd_a    = '0;
        fwd_b    = '0;
        ld_hit_a = 1'b0;
        ld_hit_b = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (sb.use_a && slot_vld_q[k-1] && slot_rd_q[k-1] == sb.src_a && sb.src_a != '0) begin
                fwd_a    = FW'(k);
                ld_hit_a = slot_ld_q[k-1] && (k < LOAD_READY);
            end
            if (sb.use_b && slot_vld_q[k-1] && slot_rd_q[k-1] == sb.src_b && sb.src_b != '0) begin
                fwd_b    = FW'(k);
                ld_hit_b = slot_ld_q[k-1] && (k < LOAD_READY);
            end
        end
    end

    assign md_busy = (md_cnt_q != '0);
    assign md_done = (md_cnt_q == CW'(1));
    assign stall   = sb.issue_valid && (ld_hit_a || ld_hit_b || md_busy);
    assign fire    = sb.issue_valid && !stall && !sb.flush;
    assign md_fire = fire && sb.issue_is_md;

    // A firing mul/div enters as a bubble; its result is injected into slot 1 when the count expires.
    always_comb begin
        slot1_vld_d = 1'b0;
        slot1_ld_d  = 1'b0;
        slot1_rd_d  = '0;
        if (md_done) begin
            slot1_vld_d = md_we_q && (md_rd_q != '0);
            slot1_rd_d  = md_rd_q;
        end else if (fire && !sb.issue_is_md) begin
            slot1_vld_d = sb.issue_we && (sb.issue_rd != '0);
            slot1_ld_d  = sb.issue_is_load;
            slot1_rd_d  = sb.issue_rd;
        end
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        md_rd_d  = md_rd_q;
        md_we_d  = md_we_q;
        if (md_fire) begin
            md_cnt_d = CW'(MD_CYCLES);
            md_rd_d  = sb.issue_rd;
            md_we_d  = sb.issue_we;
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_vld_q <= '0;
            slot_ld_q  <= '0;
            for (int k = 0; k < DEPTH; k++) slot_rd_q[k] <= '0;
            md_cnt_q   <= '0;
            md_rd_q    <= '0;
            md_we_q    <= 1'b0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                slot_vld_q[k] <= slot_vld_q[k-1];
                slot_ld_q[k]  <= slot_ld_q[k-1];
                slot_rd_q[k]  <= slot_rd_q[k-1];
            end
            slot_vld_q[0] <= slot1_vld_d;
            slot_ld_q[0]  <= slot1_ld_d;
            slot_rd_q[0]  <= slot1_rd_d;
            md_cnt_q      <= md_cnt_d;
            md_rd_q       <= md_rd_d;
            md_we_q       <= md_we_d;
        end
    end

    assign sb.issue_fire = fire;
    assign sb.stall      = stall;
    assign sb.fwd_a      = fwd_a;
    assign sb.fwd_b      = fwd_b;
    assign sb.md_busy    = md_busy;
    assign sb.slot_valid = slot_vld_q;
endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Vector-table bench for pipeline_scoreboard (DEPTH=3, LOAD_READY=2, MD_CYCLES=4) with a queued expectation scoreboard.
module tb_pipeline_scoreboard;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    pipeline_scoreboard_if #(.REG_BITS(5), .DEPTH(3)) sbif ();

    pipeline_scoreboard #(
        .REG_BITS(5), .DEPTH(3), .LOAD_READY(2), .MD_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sb   (sbif)
    );

    typedef struct {
        logic       vld, we, ld, md, ua, ub, fl;
        logic [4:0] rd, sa, sbs;
        logic       e_fire, e_stall, e_busy;
        logic [1:0] e_fa, e_fb;
        logic [2:0] e_sv;
    } vec_t;

    typedef struct {
        int         idx;
        logic       fire, stall, busy;
        logic [1:0] fa, fb;
        logic [2:0] sv;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    function automatic vec_t mk(input logic vld, we, input int rd, input logic ld, md,
                                input int sa, input logic ua, input int sbs, input logic ub, fl,
                                input logic f, st, input int fa, fb, input logic bz, input logic [2:0] sv);
        vec_t v;
        v.vld = vld; v.we = we; v.rd = 5'(rd); v.ld = ld; v.md = md;
        v.sa = 5'(sa); v.ua = ua; v.sbs = 5'(sbs); v.ub = ub; v.fl = fl;
        v.e_fire = f; v.e_stall = st; v.e_fa = 2'(fa); v.e_fb = 2'(fb); v.e_busy = bz; v.e_sv = sv;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        sbif.issue_valid   = v.vld;
        sbif.issue_we      = v.we;
        sbif.issue_rd      = v.rd;
        sbif.issue_is_load = v.ld;
        sbif.issue_is_md   = v.md;
        sbif.src_a         = v.sa;
        sbif.use_a         = v.ua;
        sbif.src_b         = v.sbs;
        sbif.use_b         = v.ub;
        sbif.flush         = v.fl;
    endtask

    task automatic chk_all(input string tag, input logic f, st, bz, input logic [1:0] fa, fb, input logic [2:0] sv);
        chk({tag, " fire"},  32'(sbif.issue_fire), 32'(f));
        chk({tag, " stall"}, 32'(sbif.stall),      32'(st));
        chk({tag, " fwd_a"}, 32'(sbif.fwd_a),      32'(fa));
        chk({tag, " fwd_b"}, 32'(sbif.fwd_b),      32'(fb));
        chk({tag, " busy"},  32'(sbif.md_busy),    32'(bz));
        chk({tag, " slots"}, 32'(sbif.slot_valid), 32'(sv));
    endtask

    initial begin
        vec_t idle;
        exp_t e;
        idle = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,3'b000);

        // ALU chain on r3
        vecs.push_back(mk(1,1,3,0,0, 0,0,0,0,0, 1,0,0,0,0,3'b000));
        vecs.push_back(mk(1,0,0,0,0, 3,1,0,0,0, 1,0,1,0,0,3'b001));
        vecs.push_back(mk(1,0,0,0,0, 3,1,0,0,0, 1,0,2,0,0,3'b010));
        vecs.push_back(mk(1,0,0,0,0, 3,1,0,0,0, 1,0,3,0,0,3'b100));
        vecs.push_back(mk(1,0,0,0,0, 3,1,0,0,0, 1,0,0,0,0,3'b000));
        // load-use on r5 via operand b
        vecs.push_back(mk(1,1,5,1,0, 0,0,0,0,0, 1,0,0,0,0,3'b000));
        vecs.push_back(mk(1,1,6,0,0, 0,0,5,1,0, 0,1,0,1,0,3'b001));
        vecs.push_back(mk(1,1,6,0,0, 0,0,5,1,0, 1,0,0,2,0,3'b010));
        vecs.push_back(mk(0,0,0,0,0, 6,1,5,1,0, 0,0,1,3,0,3'b101));
        // zero register
        vecs.push_back(mk(1,1,0,0,0, 0,0,0,0,0, 1,0,0,0,0,3'b010));
        vecs.push_back(mk(1,0,0,0,0, 0,1,0,0,0, 1,0,0,0,0,3'b100));
        // youngest wins with two writers of r4
        vecs.push_back(mk(1,1,4,0,0, 0,0,0,0,0, 1,0,0,0,0,3'b000));
        vecs.push_back(mk(1,1,4,0,0, 4,1,0,0,0, 1,0,1,0,0,3'b001));
        vecs.push_back(mk(0,0,0,0,0, 4,1,4,1,0, 0,0,1,1,0,3'b011));
        vecs.push_back(mk(0,0,0,0,0, 4,1,0,0,0, 0,0,2,0,0,3'b110));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,3'b100));
        // younger load shadows older ALU writer of the same register
        vecs.push_back(mk(1,1,4,0,0, 0,0,0,0,0, 1,0,0,0,0,3'b000));
        vecs.push_back(mk(1,1,4,1,0, 0,0,0,0,0, 1,0,0,0,0,3'b001));
        vecs.push_back(mk(1,0,0,0,0, 4,1,0,0,0, 0,1,1,0,0,3'b011));
        vecs.push_back(mk(1,0,0,0,0, 4,1,0,0,0, 1,0,2,0,0,3'b110));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,3'b100));
        // flush kills an unhazarded issue
        vecs.push_back(mk(1,1,9,0,0, 0,0,0,0,1, 0,0,0,0,0,3'b000));
        vecs.push_back(mk(0,0,0,0,0, 9,1,0,0,0, 0,0,0,0,0,3'b000));
        // mul r7, 4-cycle occupancy, flush in the middle
        vecs.push_back(mk(1,1,7,0,1, 0,0,0,0,0, 1,0,0,0,0,3'b000));
        vecs.push_back(mk(1,1,8,0,0, 0,0,0,0,0, 0,1,0,0,1,3'b000));
        vecs.push_back(mk(1,1,8,0,0, 0,0,0,0,1, 0,1,0,0,1,3'b000));
        vecs.push_back(mk(1,1,8,0,0, 0,0,0,0,0, 0,1,0,0,1,3'b000));
        vecs.push_back(mk(1,1,8,0,0, 0,0,0,0,0, 0,1,0,0,1,3'b000));
        vecs.push_back(mk(1,0,0,0,0, 7,1,0,0,0, 1,0,1,0,0,3'b001));
        vecs.push_back(mk(0,0,0,0,0, 7,1,0,0,0, 0,0,2,0,0,3'b010));
        // md fire under flush is discarded
        vecs.push_back(mk(1,1,10,0,1, 0,0,0,0,1, 0,0,0,0,0,3'b100));
        vecs.push_back(idle);
        vecs.push_back(idle);

        // Outputs while reset is held
        drive(mk(1,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,3'b000));
        #3;
        chk_all("rst", 1, 0, 0, 0, 0, 3'b000);
        sbif.flush = 1'b1;
        #1;
        chk("rst flush fire", 32'(sbif.issue_fire), 32'd0);
        drive(idle);
        #8 reset = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clock);
            #1;
            drive(vecs[i]);
            e.idx = i; e.fire = vecs[i].e_fire; e.stall = vecs[i].e_stall; e.busy = vecs[i].e_busy;
            e.fa = vecs[i].e_fa; e.fb = vecs[i].e_fb; e.sv = vecs[i].e_sv;
            exp_q.push_back(e);
            @(negedge clock);
            e = exp_q.pop_front();
            chk_all($sformatf("v%0d", e.idx), e.fire, e.stall, e.busy, e.fa, e.fb, e.sv);
        end

        // Async reset with full slots and an md in flight
        foreach (vecs[i]) if (i < 0) drive(idle);
        for (int r = 1; r <= 3; r++) begin
            @(posedge clock);
            #1;
            drive(mk(1,1,r,0,0, 0,0,0,0,0, 0,0,0,0,0,3'b000));
        end
        @(posedge clock);
        #1;
        drive(mk(1,1,7,0,1, 0,0,0,0,0, 0,0,0,0,0,3'b000));
        @(negedge clock);
        chk_all("full", 1, 0, 0, 0, 0, 3'b111);
        @(posedge clock);
        #1;
        drive(mk(1,1,8,0,0, 0,0,0,0,0, 0,0,0,0,0,3'b000));
        @(negedge clock);
        chk_all("md pre-rst", 0, 1, 1, 0, 0, 3'b110);
        #2 reset = 1'b0;
        #1;
        chk_all("rst mid-md", 1, 0, 0, 0, 0, 3'b000);
        @(posedge clock);
        #4;
        drive(idle);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            chk($sformatf("post-rst%0d slots", c), 32'(sbif.slot_valid), 32'd0);
            chk($sformatf("post-rst%0d busy", c),  32'(sbif.md_busy),    32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
